// File: rtl/lifo_stack_ctrl.sv
// LIFO stack controller: push / pop / replace-top / clear, occupancy count, level flags, overflow/underflow reporting.
// Define STACK_ERR_STICKY_EN to make overflow/underflow sticky until clear or reset (default: one-cycle pulses).
module lifo_stack_ctrl #(
    parameter int D     = 32,
    parameter int A     = 4,
    parameter int AF_TH = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] wr_data,
    output logic [D-1:0] rd_data,
    output logic [A:0]   count,
    output logic         empty,
    output logic         full,
    output logic         almost_full,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH   = 2 ** A;
    localparam logic [A:0] DEPTH_C = (A + 1)'(DEPTH);
    localparam logic [A:0] AF_C    = (A + 1)'(AF_TH);
    localparam logic [A:0] ONE_C   = (A + 1)'(1);

    logic [D-1:0] mem [DEPTH];
    logic [A:0]   count_q;
    logic [A:0]   top_idx;
    logic [A-1:0] top_addr;
    logic [A-1:0] wr_addr;
    logic         wr_en;
    logic         ovf_ev;
    logic         unf_ev;
    logic         ovf_q;
    logic         unf_q;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    assign top_idx  = count_q - ONE_C;
    assign top_addr = top_idx[A-1:0];

    // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
    assign wr_en   = !reset && !clear && push && (pop || !full);
    assign wr_addr = (pop && !empty) ? top_addr : count_q[A-1:0];

    assign ovf_ev = push && !pop && full;
    assign unf_ev = pop && !push && empty;

    assign rd_data = empty ? '0 : mem[top_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (push && !pop && !full) begin
                count_q <= count_q + ONE_C;
            end else if (pop && !push && !empty) begin
                count_q <= count_q - ONE_C;
            end else if (push && pop && empty) begin
                count_q <= ONE_C;
            end
`ifdef STACK_ERR_STICKY_EN
            ovf_q <= ovf_q | ovf_ev;
            unf_q <= unf_q | unf_ev;
`else
            ovf_q <= ovf_ev;
            unf_q <= unf_ev;
`endif
        end
    end

endmodule
